// File: rtl/fetch_stage.sv
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch stage. Owns the PC, issues single-outstanding
//                word reads over req/gnt/rvalid, buffers returned words in an
//                in-order queue and presents them to decode as a valid/ready
//                stream. Taken-branch redirects flush all wrong-path words.
//  Options     : FETCH_PERF_EN - builds saturating pop/bubble counters;
//                when undefined perf_fetched/perf_bubbles are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter int                         ADDRESS_WIDTH = 32,
  parameter int                         QUEUE_DEPTH   = 2,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = 'hBFC00000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [ADDRESS_WIDTH-1:0] imem_rdata,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [ADDRESS_WIDTH-1:0] id_instr,
  output logic [ADDRESS_WIDTH-1:0] id_pc,
  output logic [ADDRESS_WIDTH-1:0] id_pcplus4,
  output logic [31:0]              perf_fetched,
  output logic [31:0]              perf_bubbles
);

  localparam int                 c_PTR_W = $clog2(QUEUE_DEPTH);
  localparam int                 c_CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(QUEUE_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] c_ALIGN_MASK = ~ADDRESS_WIDTH'(3);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_DROP = 2'd2;

  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  logic [ADDRESS_WIDTH-1:0] r_fetch_pc;
  logic [ADDRESS_WIDTH-1:0] r_req_pc;
  logic [ADDRESS_WIDTH-1:0] r_q_instr [QUEUE_DEPTH];
  logic [ADDRESS_WIDTH-1:0] r_q_pc    [QUEUE_DEPTH];
  logic [c_PTR_W-1:0]       r_rd_ptr;
  logic [c_PTR_W-1:0]       r_wr_ptr;
  logic [c_CNT_W-1:0]       r_count;

  logic                     w_busy;
  logic                     w_space;
  logic                     w_issue_ok;
  logic                     w_req;
  logic                     w_hs;
  logic                     w_push;
  logic                     w_id_valid;
  logic                     w_pop;
  logic [ADDRESS_WIDTH-1:0] w_redirect_pc;

  // Space counts the outstanding request as occupied; a same-cycle pop does not help.
  assign w_busy        = (r_state != c_IDLE);
  assign w_space       = (r_count + c_CNT_W'(w_busy)) < c_DEPTH;
  assign w_issue_ok    = (r_state == c_IDLE) || ((r_state == c_WAIT) && imem_rvalid);
  assign w_req         = !rst && !redirect && w_space && w_issue_ok;
  assign w_hs          = w_req && imem_gnt;
  assign w_push        = (r_state == c_WAIT) && imem_rvalid && !redirect;
  assign w_id_valid    = (r_count != '0) && !redirect;
  assign w_pop         = w_id_valid && id_ready;
  assign w_redirect_pc = redirect_pc & c_ALIGN_MASK;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_hs) begin
          w_state_nxt = c_WAIT;
        end
      end
      c_WAIT: begin
        if (redirect) begin
          w_state_nxt = imem_rvalid ? c_IDLE : c_DROP;
        end else if (imem_rvalid) begin
          w_state_nxt = w_hs ? c_WAIT : c_IDLE;
        end
      end
      c_DROP: begin
        if (imem_rvalid) begin
          w_state_nxt = c_IDLE;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    imem_req   = w_req;
    imem_addr  = r_fetch_pc;
    id_valid   = w_id_valid;
    id_instr   = '0;
    id_pc      = '0;
    id_pcplus4 = '0;
    if (w_id_valid) begin
      id_instr   = r_q_instr[r_rd_ptr];
      id_pc      = r_q_pc[r_rd_ptr];
      id_pcplus4 = r_q_pc[r_rd_ptr] + ADDRESS_WIDTH'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC & c_ALIGN_MASK;
      r_req_pc   <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect) begin
      r_fetch_pc <= w_redirect_pc;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_hs) begin
        r_fetch_pc <= r_fetch_pc + ADDRESS_WIDTH'(4);
        r_req_pc   <= r_fetch_pc;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: outputs are gated by id_valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= imem_rdata;
      r_q_pc[r_wr_ptr]    <= r_req_pc;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_bubbles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_bubbles <= '0;
    end else begin
      if (w_pop && (r_perf_fetched != 32'hFFFF_FFFF)) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (id_ready && !w_id_valid && (r_perf_bubbles != 32'hFFFF_FFFF)) begin
        r_perf_bubbles <= r_perf_bubbles + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_bubbles = r_perf_bubbles;
`else
  assign perf_fetched = 32'd0;
  assign perf_bubbles = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage with a latency-programmable
//                memory model and an expected-PC scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam int          AW     = 32;
  localparam int          QD     = 4;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic          clk;
  logic          rst;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [AW-1:0] imem_rdata;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          id_valid;
  logic          id_ready;
  logic [AW-1:0] id_instr;
  logic [AW-1:0] id_pc;
  logic [AW-1:0] id_pcplus4;
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_bubbles;

  fetch_stage #(
    .ADDRESS_WIDTH (AW),
    .QUEUE_DEPTH   (QD),
    .RESET_PC      (RST_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_pcplus4   (id_pcplus4),
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory model: response mem_lat cycles after the handshake, one at a time.
  int          mem_lat;
  logic        m_pend;
  logic [31:0] m_addr;
  int          m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
      m_pend      <= 1'b0;
      m_addr      <= '0;
      m_cnt       <= 0;
    end else begin
      imem_rvalid <= 1'b0;
      if (m_pend) begin
        if (m_cnt == 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= mem_word(m_addr);
          m_pend      <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
      if (imem_req && imem_gnt) begin
        if (mem_lat <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= mem_word(imem_addr);
        end else begin
          m_pend <= 1'b1;
          m_addr <= imem_addr;
          m_cnt  <= mem_lat - 1;
        end
      end
    end
  end

  int          checks;
  int          errors;
  int          n_pops;
  int          n_bubbles;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[8];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic push_stream(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 200; i++) begin
      exp_q.push_back(start + 32'(4 * i));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard/monitor, sampled on the falling edge.
  task automatic mon_loop();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (imem_req) begin
          check32("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        end
        if (imem_req && imem_gnt) begin
          check32("one_outstanding", {31'd0, m_pend}, 32'd0);
        end
        if (id_valid && id_ready) begin
          n_pops++;
          if (exp_q.size() == 0) begin
            fail_timeout("unexpected_pop");
          end else begin
            e = exp_q.pop_front();
            check32("pop_pc", id_pc, e);
            check32("pop_instr", id_instr, mem_word(e));
            check32("pop_pcplus4", id_pcplus4, e + 32'd4);
          end
        end
        if (id_ready && !id_valid) begin
          n_bubbles++;
        end
      end
    end
  endtask

  task automatic do_reset(input logic ready_after);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    id_ready = 1'b0;
    redirect = 1'b0;
    imem_gnt = 1'b1;
    @(negedge clk);
    check32("rst_req", {31'd0, imem_req}, 32'd0);
    check32("rst_valid", {31'd0, id_valid}, 32'd0);
    check32("rst_id_pc", id_pc, 32'd0);
    check32("rst_id_instr", id_instr, 32'd0);
    check32("rst_id_pcplus4", id_pcplus4, 32'd0);
    check32("rst_perf_fetched", perf_fetched, 32'd0);
    check32("rst_perf_bubbles", perf_bubbles, 32'd0);
    @(posedge clk);
    #1;
    push_stream(RST_PC);
    n_pops    = 0;
    n_bubbles = 0;
    id_ready  = ready_after;
    rst       = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base;
    bit  found;
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    id_ready    = 1'b0;
    imem_gnt    = 1'b1;
    mem_lat     = 1;
    checks      = 0;
    errors      = 0;
    n_pops      = 0;
    n_bubbles   = 0;

    for (int k = 0; k < 8; k++) begin
      tbl[k].ready     = (k != 6);
      tbl[k].exp_req   = 1'b1;
      tbl[k].exp_addr  = RST_PC + 32'(4 * k);
      tbl[k].exp_valid = (k >= 2);
      tbl[k].exp_pc    = (k < 2) ? 32'd0 : ((k == 7) ? RST_PC + 32'h10 : RST_PC + 32'(4 * (k - 2)));
    end

    fork
      mon_loop();
    join_none

    // Streaming fetch after reset, one cycle of decode back-pressure
    do_reset(1'b1);
    for (int k = 0; k < 8; k++) begin
      id_ready = tbl[k].ready;
      @(negedge clk);
      check32($sformatf("t1_req[%0d]", k), {31'd0, imem_req}, {31'd0, tbl[k].exp_req});
      check32($sformatf("t1_addr[%0d]", k), imem_addr, tbl[k].exp_addr);
      check32($sformatf("t1_valid[%0d]", k), {31'd0, id_valid}, {31'd0, tbl[k].exp_valid});
      if (tbl[k].exp_valid) begin
        check32($sformatf("t1_pc[%0d]", k), id_pc, tbl[k].exp_pc);
      end
      @(posedge clk);
      #1;
    end

    // Decode stalled: queue fills to depth, then drains in order
    id_ready = 1'b0;
    tick(10);
    @(negedge clk);
    check32("t2_full_req", {31'd0, imem_req}, 32'd0);
    check32("t2_full_valid", {31'd0, id_valid}, 32'd1);
    @(posedge clk);
    #1;
    base     = n_pops;
    imem_gnt = 1'b0;
    id_ready = 1'b1;
    tick(8);
    check32("t2_drain_count", 32'(n_pops - base), 32'(QD));
    imem_gnt = 1'b1;

    // Redirect while a request is outstanding
    mem_lat = 3;
    found   = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_pend) found = 1'b1;
      else tick(1);
    end
    if (!found) fail_timeout("t3_wait_pending");
    redirect    = 1'b1;
    redirect_pc = 32'hBFC0_0103;
    push_stream(32'hBFC0_0100);
    @(negedge clk);
    check32("t3_redir_req", {31'd0, imem_req}, 32'd0);
    check32("t3_redir_valid", {31'd0, id_valid}, 32'd0);
    @(posedge clk);
    #1;
    redirect    = 1'b0;
    redirect_pc = '0;
    found       = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (id_valid) begin
        found = 1'b1;
        check32("t3_target_pc", id_pc, 32'hBFC0_0100);
      end
    end
    if (!found) fail_timeout("t3_target_valid");
    @(posedge clk);
    #1;

    // Redirect on the response cycle that fills the queue
    mem_lat  = 1;
    id_ready = 1'b0;
    tick(12);
    id_ready = 1'b1;
    mem_lat  = 2;
    tick(1);
    id_ready = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem_rvalid) found = 1'b1;
      else tick(1);
    end
    if (!found) fail_timeout("t4_wait_rvalid");
    redirect    = 1'b1;
    redirect_pc = 32'h0000_2000;
    push_stream(32'h0000_2000);
    @(negedge clk);
    check32("t4_redir_valid", {31'd0, id_valid}, 32'd0);
    @(posedge clk);
    #1;
    redirect    = 1'b0;
    redirect_pc = '0;
    @(negedge clk);
    check32("t4_after_valid", {31'd0, id_valid}, 32'd0);
    check32("t4_after_req", {31'd0, imem_req}, 32'd1);
    check32("t4_after_addr", imem_addr, 32'h0000_2000);
    @(posedge clk);
    #1;
    id_ready = 1'b1;
    tick(6);

    // Grant withheld: address held; PC wraps at the top of the address space
    imem_gnt = 1'b0;
    mem_lat  = 1;
    tick(2);
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    push_stream(32'hFFFF_FFFC);
    tick(1);
    redirect    = 1'b0;
    redirect_pc = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check32($sformatf("t5_hold_req[%0d]", i), {31'd0, imem_req}, 32'd1);
      check32($sformatf("t5_hold_addr[%0d]", i), imem_addr, 32'hFFFF_FFFC);
      @(posedge clk);
      #1;
    end
    imem_gnt = 1'b1;
    tick(1);
    @(negedge clk);
    check32("t5_wrap_req", {31'd0, imem_req}, 32'd1);
    check32("t5_wrap_addr", imem_addr, 32'h0000_0000);
    @(posedge clk);
    #1;
    tick(6);

    // Performance counters: 8 pops and 3 starved cycles since reset
    do_reset(1'b0);
    tick(12);
    imem_gnt = 1'b0;
    id_ready = 1'b1;
    tick(4);
    id_ready = 1'b0;
    imem_gnt = 1'b1;
    tick(12);
    imem_gnt = 1'b0;
    id_ready = 1'b1;
    tick(7);
    id_ready = 1'b0;
    @(negedge clk);
    check32("t6_pops_seen", 32'(n_pops), 32'd8);
    check32("t6_bubbles_seen", 32'(n_bubbles), 32'd3);
`ifdef FETCH_PERF_EN
    check32("t6_perf_fetched", perf_fetched, 32'd8);
    check32("t6_perf_bubbles", perf_bubbles, 32'd3);
`else
    check32("t6_perf_fetched", perf_fetched, 32'd0);
    check32("t6_perf_bubbles", perf_bubbles, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
